// File: rtl/delta_ctrl.sv
// delta_ctrl: microcoded sequencer for the LSTM back-propagation delta unit.
// Walks a fixed 11-step select schedule once per timestep for a programmable
// number of timesteps, then drains one cycle and pulses done.
//
// Handshake: start is a level sampled only in IDLE (num_t captured in the
// same cycle); stall is a hold request honoured only in RUN/DRAIN, freezing
// step, t_idx and every select and masking all capture strobes while high.
module delta_ctrl #(
  parameter int TS_W  = 8,
  parameter int NSTEP = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [TS_W-1:0] num_t,
  input  logic            stall,
  output logic            busy,
  output logic            done,
  output logic [TS_W-1:0] t_idx,
  output logic [3:0]      step,
  output logic [1:0]      sel_in1,
  output logic [1:0]      sel_in2,
  output logic            sel_in3,
  output logic [1:0]      sel_in4,
  output logic [2:0]      sel_in5,
  output logic [1:0]      sel_x1_1,
  output logic            sel_x1_2,
  output logic [1:0]      sel_x2_2,
  output logic            sel_as_1,
  output logic [1:0]      sel_as_2,
  output logic            sel_addsub,
  output logic [1:0]      sel_temp,
  output logic            sel_state,
  output logic            cap_dstate,
  output logic            cap_dot,
  output logic            cap_dat,
  output logic            cap_dit,
  output logic            cap_dft
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] LAST_STEP  = 4'(NSTEP - 1);
  localparam logic [3:0] DRAIN_STEP = 4'(NSTEP);

  // One word carrying every datapath select of the delta unit.
  typedef struct packed {
    logic [1:0] in1;
    logic [1:0] in2;
    logic       in3;
    logic [1:0] in4;
    logic [2:0] in5;
    logic [1:0] x1_1;
    logic       x1_2;
    logic [1:0] x2_2;
    logic       as_1;
    logic [1:0] as_2;
    logic       addsub;
    logic [1:0] temp;
  } sel_t;

  // Microcode ROM: select word for each schedule step (drain and unused = 0).
  function automatic sel_t decode_sel(input logic [3:0] s);
    sel_t r;
    r = '0;
    case (s)
      4'd0: begin
        r.in4 = 2'd1;
      end
      4'd2: begin
        r.in1 = 2'd2; r.in2 = 2'd3; r.in4 = 2'd2; r.in5 = 3'd1;
        r.x2_2 = 2'd3; r.as_2 = 2'd3; r.addsub = 1'b1;
      end
      4'd3: begin
        r.in2 = 2'd2; r.in4 = 2'd2; r.in5 = 3'd4;
      end
      4'd4: begin
        r.x1_1 = 2'd1; r.x2_2 = 2'd2; r.temp = 2'd2;
      end
      4'd5: begin
        r.in3 = 1'b1; r.in4 = 2'd2; r.x2_2 = 2'd1; r.as_1 = 1'b1;
        r.as_2 = 2'd2; r.addsub = 1'b1; r.temp = 2'd1;
      end
      4'd6: begin
        r.in1 = 2'd1; r.in4 = 2'd2; r.in5 = 3'd2; r.x1_1 = 2'd2;
        r.as_2 = 2'd1; r.temp = 2'd2;
      end
      4'd7: begin
        r.in2 = 2'd1; r.in4 = 2'd2; r.in5 = 3'd3; r.x1_2 = 1'b1;
        r.x2_2 = 2'd2; r.temp = 2'd2;
      end
      4'd8: begin
        r.in1 = 2'd3; r.in4 = 2'd2; r.in5 = 3'd3; r.x1_1 = 2'd2;
        r.x2_2 = 2'd1; r.temp = 2'd2;
      end
      4'd9: begin
        r.x1_2 = 1'b1; r.temp = 2'd2;
      end
      4'd10: begin
        r.x2_2 = 2'd1; r.temp = 2'd2;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Registered state (state is kept as a named signal for checker binding).
  logic [1:0]      state;
  logic [3:0]      step_q;
  logic [TS_W-1:0] t_idx_q;
  logic [TS_W-1:0] num_q;
  logic            busy_q;
  logic            done_q;
  logic            sel_state_q;
  sel_t            sel_q;

  // Next-state values.
  logic [1:0]      state_n;
  logic [3:0]      step_n;
  logic [TS_W-1:0] t_idx_n;
  logic [TS_W-1:0] num_n;
  logic [TS_W:0]   t_plus1;
  logic            more_ts;
  sel_t            sel_n;
  logic            sel_state_n;

  // One extra bit so t_idx+1 compares correctly at the top of the range.
  assign t_plus1 = {1'b0, t_idx_q} + {{TS_W{1'b0}}, 1'b1};
  assign more_ts = t_plus1 < {1'b0, num_q};

  // Sequencer next-state: step/timestep advance, reload and drain.
  always_comb begin
    state_n = state;
    step_n  = step_q;
    t_idx_n = t_idx_q;
    num_n   = num_q;
    case (state)
      S_IDLE: begin
        step_n  = 4'd0;
        t_idx_n = '0;
        if (start) begin
          if (num_t != '0) begin
            num_n   = num_t;
            state_n = S_RUN;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (step_q == LAST_STEP) begin
            if (more_ts) begin
              step_n  = 4'd0;
              t_idx_n = t_plus1[TS_W-1:0];
            end else begin
              state_n = S_DRAIN;
              step_n  = DRAIN_STEP;
            end
          end else begin
            step_n = step_q + 4'd1;
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          state_n = S_DONE;
          step_n  = 4'd0;
          t_idx_n = '0;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        step_n  = 4'd0;
        t_idx_n = '0;
      end
      default: begin
        state_n = S_IDLE;
        step_n  = 4'd0;
        t_idx_n = '0;
      end
    endcase
  end

  // Selects are decoded from the next step so they line up with step itself.
  always_comb begin
    sel_n       = '0;
    sel_state_n = 1'b0;
    if (state_n == S_RUN) begin
      sel_n       = decode_sel(step_n);
      sel_state_n = (step_n >= 4'd7) && (step_n <= LAST_STEP);
    end
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      step_q      <= 4'd0;
      t_idx_q     <= '0;
      num_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sel_state_q <= 1'b0;
      sel_q       <= '0;
    end else begin
      state       <= state_n;
      step_q      <= step_n;
      t_idx_q     <= t_idx_n;
      num_q       <= num_n;
      busy_q      <= (state_n == S_RUN) || (state_n == S_DRAIN);
      done_q      <= (state_n == S_DONE);
      sel_state_q <= sel_state_n;
      sel_q       <= sel_n;
    end
  end

  logic in_run;
  logic in_drain;
  assign in_run   = (state == S_RUN);
  assign in_drain = (state == S_DRAIN);

  // Capture strobes: combinational from the registered step, masked by stall.
  always_comb begin
    cap_dstate = 1'b0;
    cap_dot    = 1'b0;
    cap_dat    = 1'b0;
    cap_dit    = 1'b0;
    cap_dft    = 1'b0;
    if (!stall) begin
      cap_dstate = in_run && (step_q == 4'd6);
      cap_dot    = in_run && (step_q == 4'd7);
      cap_dat    = in_run && (step_q == 4'd9);
      cap_dit    = in_run && (step_q == LAST_STEP);
      cap_dft    = (in_run && (step_q == 4'd0) && (t_idx_q != '0)) || in_drain;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign t_idx      = t_idx_q;
  assign step       = step_q;
  assign sel_state  = sel_state_q;
  assign sel_in1    = sel_q.in1;
  assign sel_in2    = sel_q.in2;
  assign sel_in3    = sel_q.in3;
  assign sel_in4    = sel_q.in4;
  assign sel_in5    = sel_q.in5;
  assign sel_x1_1   = sel_q.x1_1;
  assign sel_x1_2   = sel_q.x1_2;
  assign sel_x2_2   = sel_q.x2_2;
  assign sel_as_1   = sel_q.as_1;
  assign sel_as_2   = sel_q.as_2;
  assign sel_addsub = sel_q.addsub;
  assign sel_temp   = sel_q.temp;

endmodule

// File: doc/delta_ctrl.md
Name: delta_ctrl

Overview:
- Microcoded sequencer for the LSTM back-propagation delta datapath.
- Drives every mux/ALU select of the delta unit through a fixed 11-step schedule per timestep.
- Repeats the schedule for a programmable number of timesteps.
- Emits capture strobes telling downstream buffers when o_dgate holds d_ot, d_at, d_it, d_ft, and when o_d_state is valid.

Parameters:
TS_W, 8, width of timestep count and index
NSTEP, 11, schedule steps per timestep (fixed schedule; not meant to be overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  request a run; sampled only in IDLE
num_t  in  TS_W  number of timesteps; sampled with start
stall  in  1  operand-not-ready hold
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at end of run
t_idx  out  TS_W  current timestep index
step  out  4  current schedule step (0-10, 11 = drain)
sel_in1  out  2  delta select
sel_in2  out  2  delta select
sel_in3  out  1  delta select
sel_in4  out  2  delta select
sel_in5  out  3  delta select
sel_x1_1  out  2  delta select
sel_x1_2  out  1  delta select
sel_x2_2  out  2  delta select
sel_as_1  out  1  delta select
sel_as_2  out  2  delta select
sel_addsub  out  1  delta select
sel_temp  out  2  delta select
sel_state  out  1  state operand source: 0 = c_t, 1 = c_t-1
cap_dstate  out  1  o_d_state valid
cap_dot  out  1  o_dgate = d_ot
cap_dat  out  1  o_dgate = d_at
cap_dit  out  1  o_dgate = d_it
cap_dft  out  1  o_dgate = d_ft

Behaviour:
- Reset: state IDLE; all outputs 0.
- State IDLE:
  - start=1 with num_t!=0: latch num_t; next cycle RUN, step=0, t_idx=0.
  - start=1 with num_t=0: go to DONE directly.
- State RUN:
  - step advances by 1 each non-stalled cycle.
  - After step 10, if t_idx+1 < latched num_t: step=0 and t_idx+1.
  - Otherwise go to DRAIN (step=11).
- State DRAIN: one non-stalled cycle, then DONE.
- State DONE: done=1 for one cycle, then IDLE.
- Output timing: selects are registered and decoded from the next-step value, so the selects for step k are valid exactly while step==k.
- Select table (fields not listed are 0):
  - s0: in4=1
  - s1: all 0
  - s2: in1=2, in2=3, in4=2, in5=1, x2_2=3, as_2=3, addsub=1
  - s3: in2=2, in4=2, in5=4
  - s4: x1_1=1, x2_2=2, temp=2
  - s5: in3=1, in4=2, x2_2=1, as_1=1, as_2=2, addsub=1, temp=1
  - s6: in1=1, in4=2, in5=2, x1_1=2, as_2=1, temp=2
  - s7: in2=1, in4=2, in5=3, x1_2=1, x2_2=2, temp=2
  - s8: in1=3, in4=2, in5=3, x1_1=2, x2_2=1, temp=2
  - s9: x1_2=1, temp=2
  - s10: x2_2=1, temp=2
  - s11 (drain): all 0
- sel_state = 1 in steps 7-10; 0 otherwise.
- Capture strobes are combinational from the registered step and are forced low whenever stall=1:
  - cap_dstate: step 6
  - cap_dot: step 7
  - cap_dat: step 9
  - cap_dit: step 10
  - cap_dft: the cycle after step 10, i.e. step 0 with t_idx>0, or step 11.
- Stall, in RUN/DRAIN: step, t_idx, selects and sel_state hold; no strobe fires; a strobe fires on the first non-stalled cycle at its step.
- Stall, in IDLE/DONE: ignored.
- start while busy or in DONE: ignored.
- start and stall together in IDLE: start is accepted.
- rst mid-run: immediate return to IDLE with all outputs 0; a new start is needed afterwards.
- t_idx wraps only through reload; the maximum run is 2^TS_W-1 timesteps.
- Latency without stall, from the start cycle to the done pulse: 11*num_t + 2 cycles.

Test Plan:
- Reset then start with num_t=1 and no stall → step 0..10, 11 on consecutive cycles; s2 selects read in1=2, in2=3, x2_2=3, as_2=3, addsub=1; cap_dot at step 7; cap_dft at step 11; done 13 cycles after start; busy low after DRAIN.
- Start with num_t=3 → t_idx steps 0, 1, 2; cap_dft at step 0 of t_idx=1 and 2 and at step 11; exactly 3 pulses of each cap_*; done after 35 cycles.
- stall held 3 cycles during step 7 → step stays 7, selects frozen (in5=3, x1_2=1), cap_dot low while stalled and high on release; done delayed by exactly 3 cycles.
- Start with num_t=0 → no RUN, busy never high, done pulses one cycle after start.
- Start pulse while busy at step 4 → ignored; run completes unchanged. rst asserted at step 5 of t_idx=1 → all outputs 0 the same cycle, IDLE; a subsequent start(num_t=1) runs cleanly.
- sel_state → 0 in s0-s6, 1 in s7-s10, 0 in drain; cap_dstate only at step 6.
